rd_ctrl_transpose: RTL and testbench

Read controller for the transpose frame buffer. After a one-cycle `rd_command` pulse, it reads one complete ROW×CLO frame out of the RAM in column-major (transposed) order. The RAM was filled row-major by the write controller. Returned RAM data is buffered in a small credit-controlled FIFO and presented on a valid/ready stream, so the downstream consumer may stall without losing data.

---
 rtl/rd_ctrl_transpose.sv | 202 ++++++++++++++++++++
 tb/tb_rd_ctrl_transpose.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_ctrl_transpose.sv
// rd_ctrl_transpose
//
// Read controller for the transpose frame buffer. A one-cycle rd_command
// starts a read of one ROW x CLO frame (stored row-major) in column-major
// order. RAM returns are tracked by a valid pipe and land in a small
// credit-controlled FIFO, which drives a valid/ready output stream.
//
// Ports:
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset
//   rd_command       - one-cycle pulse starting a frame read (IDLE only)
//   rd_en, rd_addr   - RAM read strobe and address
//   rd_data          - RAM data, valid RD_LATENCY cycles after rd_en
//   data_out         - stream data (FIFO head, 0 when not valid)
//   data_out_valid   - stream valid
//   data_out_ready   - stream ready
//   data_out_last    - (RD_CTRL_LAST_EN only) beat ends a transposed line
//   rd_busy          - high from frame start until the final beat is taken
//   rd_finish        - one-cycle pulse after the final beat is accepted
//
// Optional feature macro: RD_CTRL_LAST_EN adds data_out_last and a last-flag
// lane through the valid pipe and FIFO.
module rd_ctrl_transpose #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int ROW        = 64,
    parameter int CLO        = 2400,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_command,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
`ifdef RD_CTRL_LAST_EN
    output logic                  data_out_last,
`endif
    output logic                  rd_busy,
    output logic                  rd_finish
);

    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int FRAME      = ROW * CLO;
    localparam int RW         = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW         = (CLO > 1) ? $clog2(CLO) : 1;
    localparam int BW         = $clog2(FRAME + 1);
    localparam int PW         = $clog2(FIFO_DEPTH);
    // One spare bit so inflight + fifo_count cannot wrap.
    localparam int NW         = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state, state_next;
    logic [RW-1:0]         row_idx;
    logic [CW-1:0]         col_idx;
    logic                  row_last, col_last;
    logic                  start;
    logic [RD_LATENCY-1:0] vpipe;
    logic [NW-1:0]         inflight;
    logic [NW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop;
    logic [BW-1:0]         beat_cnt;
    logic                  final_beat;

    function automatic logic [NW-1:0] popcount(input logic [RD_LATENCY-1:0] v);
        logic [NW-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LATENCY; i++) n = n + NW'(v[i]);
        return n;
    endfunction

    // FIFO depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign row_last   = (row_idx == RW'(ROW - 1));
    assign col_last   = (col_idx == CW'(CLO - 1));
    assign inflight   = popcount(vpipe);
    assign push       = vpipe[RD_LATENCY-1];
    assign pop        = data_out_valid && data_out_ready;
    assign final_beat = pop && (beat_cnt == BW'(FRAME - 1));
    // rd_command coinciding with the rd_finish pulse is deliberately dropped.
    assign start      = (state == IDLE) && rd_command && !rd_finish;
    assign rd_busy    = (state != IDLE);

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // ---- FSM next state and credit-gated read strobe ----
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = READ;
            end
            READ: begin
                // Every outstanding read owns a FIFO slot, so the FIFO cannot overflow.
                rd_en = ((inflight + fifo_count) < NW'(FIFO_DEPTH));
                if (rd_en && row_last && col_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (final_beat) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- Address generation: row is the inner loop, stride CLO ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            row_idx <= '0;
            col_idx <= '0;
        end else if (start) begin
            rd_addr <= '0;
            row_idx <= '0;
            col_idx <= '0;
        end else if (rd_en) begin
            if (row_last) begin
                row_idx <= '0;
                if (col_last) begin
                    col_idx <= '0;
                    rd_addr <= '0;
                end else begin
                    col_idx <= col_idx + CW'(1);
                    // Top of the next column is simply its column index.
                    rd_addr <= ADDR_WIDTH'(col_idx) + ADDR_WIDTH'(1);
                end
            end else begin
                row_idx <= row_idx + RW'(1);
                rd_addr <= rd_addr + ADDR_WIDTH'(CLO);
            end
        end
    end

    // ---- RAM latency valid pipe ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) vpipe[i] <= vpipe[i-1];
        end
    end

    // ---- Output FIFO ----
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + NW'(push) - NW'(pop);
        end
    end

    assign data_out_valid = (fifo_count != '0);
    assign data_out       = data_out_valid ? fifo_mem[rd_ptr] : '0;

`ifdef RD_CTRL_LAST_EN
    logic [RD_LATENCY-1:0] lpipe;
    logic                  fifo_last [FIFO_DEPTH];

    // Last flag travels beside the valid bit; it is only looked at when valid.
    always_ff @(posedge clk) begin
        lpipe[0] <= row_last;
        for (int i = 1; i < RD_LATENCY; i++) lpipe[i] <= lpipe[i-1];
        if (push) fifo_last[wr_ptr] <= lpipe[RD_LATENCY-1];
    end

    assign data_out_last = data_out_valid ? fifo_last[rd_ptr] : 1'b0;
`endif

    // ---- Beat counter and finish pulse ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            rd_finish <= 1'b0;
        end else begin
            rd_finish <= final_beat;
            if (final_beat || start) beat_cnt <= '0;
            else if (pop)            beat_cnt <= beat_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_rd_ctrl_transpose.sv
module tb_rd_ctrl_transpose;

    localparam int ROW = 4;
    localparam int CLO = 3;
    localparam int L   = 2;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int N   = ROW * CLO;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_command;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          rd_busy;
    logic          rd_finish;
`ifdef RD_CTRL_LAST_EN
    logic          data_out_last;
`endif

    always #5 clk = ~clk;

    rd_ctrl_transpose #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW(ROW), .CLO(CLO), .RD_LATENCY(L)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rd_command(rd_command),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
`ifdef RD_CTRL_LAST_EN
        .data_out_last(data_out_last),
`endif
        .rd_busy(rd_busy),
        .rd_finish(rd_finish)
    );

    // RAM model: word = address, L cycles after rd_en; junk when not read.
    logic [AW-1:0] ram_pipe [L];
    always_ff @(posedge clk) begin
        ram_pipe[0] <= rd_en ? rd_addr : AW'(8'hEE);
        for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign rd_data = DW'(ram_pipe[L-1]);

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc, first_valid, finish_cnt, finish_cyc, last_acc, beats, issued, max_occ;
    bit            rnd_ready;
    bit            prev_stall;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_rd_en"},     32'(rd_en),          0);
        chk({pfx, "_rd_addr"},   32'(rd_addr),        0);
        chk({pfx, "_data_out"},  32'(data_out),       0);
        chk({pfx, "_valid"},     32'(data_out_valid), 0);
        chk({pfx, "_rd_busy"},   32'(rd_busy),        0);
        chk({pfx, "_rd_finish"}, 32'(rd_finish),      0);
    endtask

    // One clock: sample at the falling edge, choose ready, score any handshake.
    task automatic cycle();
        exp_t e;
        int   occ;
        @(negedge clk);
        cyc++;
        data_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (prev_stall) begin
            chk("stall_valid_hold", 32'(data_out_valid), 1);
            chk("stall_data_hold",  32'(data_out),       32'(prev_data));
        end
        if (rd_en) issued++;
        occ = issued - beats;
        if (occ > max_occ) max_occ = occ;
        if (data_out_valid && first_valid < 0) first_valid = cyc;
        if (rd_finish) begin
            finish_cnt++;
            finish_cyc = cyc;
        end
        if (data_out_valid && data_out_ready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data", 32'(data_out), 32'(e.data));
`ifdef RD_CTRL_LAST_EN
                chk("last", 32'(data_out_last), 32'(e.last));
`endif
            end
            beats++;
            last_acc = cyc;
        end
        prev_stall = data_out_valid && !data_out_ready;
        prev_data  = data_out;
    endtask

    // Called at a falling edge; drives rd_command in that cycle (cycle T).
    task automatic run_frame(input bit rnd, input int again_at, input int rst_at);
        int budget;
        bit sent;
        for (int c = 0; c < CLO; c++) begin
            for (int r = 0; r < ROW; r++) begin
                exp_t e;
                e.data = DW'(r * CLO + c);
                e.last = (r == ROW - 1);
                exp_q.push_back(e);
            end
        end
        rnd_ready  = rnd;
        cyc        = 0;
        first_valid = -1;
        finish_cnt = 0;
        finish_cyc = -1;
        last_acc   = -1;
        beats      = 0;
        issued     = 0;
        max_occ    = 0;
        sent       = 1'b0;
        budget     = 0;
        rd_command = 1'b1;
        while (finish_cnt == 0 && budget < 500) begin
            cycle();
            budget++;
            rd_command = 1'b0;
            if (cyc == 1) begin
                chk("start_rd_en",   32'(rd_en),   1);
                chk("start_rd_addr", 32'(rd_addr), 0);
                chk("start_rd_busy", 32'(rd_busy), 1);
            end
            if (rst_at >= 0 && beats == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("midframe_reset");
                exp_q.delete();
                repeat (2) @(negedge clk);
                rst_n      = 1'b1;
                prev_stall = 1'b0;
                return;
            end
            if (again_at >= 0 && beats == again_at && !sent) begin
                rd_command = 1'b1;
                sent       = 1'b1;
            end
        end
        chk("finish_seen",            32'(finish_cnt),       1);
        chk("busy_low_at_finish",     32'(rd_busy),          0);
        chk("finish_after_last_beat", 32'(finish_cyc),       32'(last_acc + 1));
        chk("beat_count",             32'(beats),            N);
        chk("queue_drained",          32'(exp_q.size()),     0);
        chk("fifo_occupancy_bound",   32'(max_occ <= L + 2), 1);
        if (!rnd) begin
            chk("first_valid_cycle", 32'(first_valid), L + 2);
            chk("last_accept_cycle", 32'(last_acc),    N + L + 1);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        rd_command     = 1'b0;
        data_out_ready = 1'b1;
        rnd_ready      = 1'b0;
        prev_stall     = 1'b0;
        prev_data      = '0;
        cyc            = 0;
        issued         = 0;
        beats          = 0;
        max_occ        = 0;
        first_valid    = -1;
        finish_cnt     = 0;
        finish_cyc     = -1;
        last_acc       = -1;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        cycle();
        cycle();

        // Plain frame with ready held high.
        run_frame(1'b0, -1, -1);

        // rd_command in the rd_finish cycle is dropped.
        rd_command = 1'b1;
        cycle();
        rd_command = 1'b0;
        chk("cmd_at_finish_busy", 32'(rd_busy), 0);
        chk("cmd_at_finish_rd_en", 32'(rd_en), 0);

        // One cycle later a new frame starts; a repeat command at beat 5 is ignored.
        run_frame(1'b0, 5, -1);
        cycle();

        // Reset at beat 6 with reads in flight, then a clean restart.
        run_frame(1'b0, -1, 6);
        cycle();
        chk_reset_outputs("after_reset_idle");
        run_frame(1'b0, -1, -1);
        cycle();

        // Random back-pressure frames.
        for (int f = 0; f < 4; f++) begin
            run_frame(1'b1, -1, -1);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
